minterm_sweep_driver: RTL

//  Upstream stimulus stage for the three-input gate-level function blocks (x,y,z -> F).
//  On start, drives x,y,z through minterms 0..7 in ascending order and holds each for HOLD_CYCLES clocks.

---
 rtl/minterm_sweep_driver.sv | 112 +++++++++++
 1 files changed

// File: rtl/minterm_sweep_driver.sv
// Clocked 3-input minterm sweep: drives {x,y,z} through 0..7, samples f_in per minterm, reports truth table.
// Optional TT_COMPARE_EN: registers mismatch = (captured table != exp_tbl) alongside done.
module minterm_sweep_driver #(
  parameter int HOLD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  input  logic [7:0] exp_tbl,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_tbl,
  output logic       mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_n;
  logic [2:0]       idx, idx_n;
  logic [2:0]       xyz, xyz_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n;
  logic [7:0]       tbl_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    xyz_n   = xyz;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    tbl_n   = truth_tbl;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = DRIVE;
          busy_n  = 1'b1;
          idx_n   = 3'd0;
          xyz_n   = 3'd0;
          cnt_n   = RELOAD;
          tbl_n   = 8'h00;
        end
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - ONE;
        end else begin
          // Capture on the last hold cycle, then advance or finish.
          tbl_n[idx] = f_in;
          if (idx != 3'd7) begin
            idx_n = idx + 3'd1;
            xyz_n = idx + 3'd1;
            cnt_n = RELOAD;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      xyz       <= 3'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth_tbl <= 8'h00;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      xyz       <= xyz_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      truth_tbl <= tbl_n;
    end
  end

  assign {x, y, z} = xyz;

`ifdef TT_COMPARE_EN
  // Cleared on an accepted start, set with done, otherwise held.
  always_ff @(posedge clk) begin
    if (rst)
      mismatch <= 1'b0;
    else if (state == IDLE && start)
      mismatch <= 1'b0;
    else if (done_n)
      mismatch <= (tbl_n != exp_tbl);
  end
`else
  logic unused_exp_tbl;
  assign unused_exp_tbl = ^exp_tbl;
  assign mismatch       = 1'b0;
`endif

endmodule
